// File: rtl/icache_pkg.sv
// Shared constants and types for the instruction cache.
package icache_pkg;

  localparam int DATA_WIDTH         = 32;
  // Only pc[17:0] take part in the lookup; address bits above are ignored.
  localparam int RAM_ADDRESS_WIDTH  = 18;
  localparam int ICACHE_LINES       = 64;
  localparam int ICACHE_INDEX_WIDTH = $clog2(ICACHE_LINES);
  localparam int ICACHE_TAG_WIDTH   = RAM_ADDRESS_WIDTH - 2 - ICACHE_INDEX_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. A hit answers one cycle
// after the request. A miss raises a level request to memCtrl and answers one
// cycle after the memory word arrives. A misbranch flush drops any response
// that is still pending. rdy=0 freezes every register.
//
// Handshake: in_fetch_req is sampled only while out_busy=0.
// out_mem_req stays high, with out_mem_addr stable, until in_mem_valid
// pulses or a misbranch aborts the miss. out_fetch_valid is a one-cycle
// pulse per completed request.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = ICACHE_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetch_req,
  input  logic [31:0] in_fetch_pc,
  input  logic        in_misbranch,
  output logic        out_fetch_valid,
  output logic [31:0] out_fetch_instr,
  output logic        out_busy,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_valid,
  input  logic [31:0] in_mem_data,
  output logic        dbg_state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = RAM_ADDRESS_WIDTH - 2 - IDX_W;

  icache_state_e state, state_n;

  logic [LINES-1:0]      line_valid;
  logic [TAG_W-1:0]      line_tag  [LINES];
  logic [DATA_WIDTH-1:0] line_data [LINES];

  logic [IDX_W-1:0] pc_idx, miss_idx;
  logic [TAG_W-1:0] pc_tag, miss_tag;
  logic             hit;

  logic        valid_n;
  logic [31:0] instr_n;
  logic [31:0] addr_n;
  logic        fill_en;

  logic unused_pc_bits;
  assign unused_pc_bits = ^in_fetch_pc[1:0];

  // The latched miss address doubles as the fill address.
  assign pc_idx   = in_fetch_pc[2+IDX_W-1:2];
  assign pc_tag   = in_fetch_pc[RAM_ADDRESS_WIDTH-1:2+IDX_W];
  assign miss_idx = out_mem_addr[2+IDX_W-1:2];
  assign miss_tag = out_mem_addr[RAM_ADDRESS_WIDTH-1:2+IDX_W];
  assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);

  assign out_busy    = (state == S_MISS);
  assign out_mem_req = (state == S_MISS);
  assign dbg_state   = state;

  // Next-state and registered-output decisions for the lookup/miss FSM.
  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    instr_n = out_fetch_instr;
    addr_n  = out_mem_addr;
    fill_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_fetch_req && !in_misbranch) begin
          if (hit) begin
            valid_n = 1'b1;
            instr_n = line_data[pc_idx];
          end else begin
            state_n = S_MISS;
            addr_n  = {in_fetch_pc[31:2], 2'b00};
          end
        end
      end
      S_MISS: begin
        if (in_mem_valid) begin
          // The line is filled even when flushed: the data is still correct.
          fill_en = 1'b1;
          state_n = S_IDLE;
          if (!in_misbranch) begin
            valid_n = 1'b1;
            instr_n = in_mem_data;
          end
        end else if (in_misbranch) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; held while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      out_fetch_valid <= 1'b0;
      out_fetch_instr <= '0;
      out_mem_addr    <= '0;
    end else if (rdy) begin
      state           <= state_n;
      out_fetch_valid <= valid_n;
      out_fetch_instr <= instr_n;
      out_mem_addr    <= addr_n;
    end
  end

  // Valid bits are the only part of the array that needs a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (rdy && fill_en) begin
      line_valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data storage written on a fill.
  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      line_tag[miss_idx]  <= miss_tag;
      line_data[miss_idx] <= in_mem_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache. The reference model treats each
// line as "holds word address W (mod 2^16) with data D".
module tb_icache;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        in_fetch_req = 1'b0;
  logic [31:0] in_fetch_pc = '0;
  logic        in_misbranch = 1'b0;
  logic        out_fetch_valid;
  logic [31:0] out_fetch_instr;
  logic        out_busy;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic        in_mem_valid = 1'b0;
  logic [31:0] in_mem_data = '0;
  logic        dbg_state;

  icache #(.LINES(LINES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_req(in_fetch_req), .in_fetch_pc(in_fetch_pc),
    .in_misbranch(in_misbranch),
    .out_fetch_valid(out_fetch_valid), .out_fetch_instr(out_fetch_instr),
    .out_busy(out_busy), .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_valid(in_mem_valid), .in_mem_data(in_mem_data),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Reference model and scoreboard.
  bit          mdl_valid [LINES];
  int unsigned mdl_word  [LINES];
  logic [31:0] mdl_data  [LINES];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % LINES);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] pc);
    return (pc >> 2) % 65536;
  endfunction

  function automatic bit mdl_hit(input logic [31:0] pc);
    return mdl_valid[idx_of(pc)] && (mdl_word[idx_of(pc)] == word_of(pc));
  endfunction

  task automatic mdl_fill(input logic [31:0] pc, input logic [31:0] d);
    mdl_valid[idx_of(pc)] = 1'b1;
    mdl_word[idx_of(pc)]  = word_of(pc);
    mdl_data[idx_of(pc)]  = d;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
  endtask

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  task automatic check_resp(input string tg);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_sb: observed response expected none queued", tg);
    end else begin
      e = exp_q.pop_front();
      check({tg, "_instr"}, out_fetch_instr, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch from request to response. misb_at selects a wait cycle for a
  // flush (-1 for none); misb_fill flushes together with the memory word.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] mdata, input int lat,
                          input int misb_at, input bit misb_fill, input string tg);
    bit hit;
    int i;
    hit = mdl_hit(pc);
    i   = idx_of(pc);
    in_fetch_req = 1'b1;
    in_fetch_pc  = pc;
    tick();
    in_fetch_req = 1'b0;
    in_fetch_pc  = $urandom;
    if (hit) begin
      exp_q.push_back(mdl_data[i]);
      check({tg, "_hit_valid"}, out_fetch_valid, 1);
      check_resp(tg);
      check({tg, "_hit_memreq"}, out_mem_req, 0);
      check({tg, "_hit_busy"}, out_busy, 0);
      tick();
      check({tg, "_hit_pulse_end"}, out_fetch_valid, 0);
      return;
    end
    check({tg, "_miss_busy"}, out_busy, 1);
    check({tg, "_miss_memreq"}, out_mem_req, 1);
    check({tg, "_miss_addr"}, out_mem_addr, {pc[31:2], 2'b00});
    check({tg, "_miss_novalid"}, out_fetch_valid, 0);
    for (int c = 0; c < lat; c++) begin
      if (c == misb_at) begin
        in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        check({tg, "_flush_memreq"}, out_mem_req, 0);
        check({tg, "_flush_busy"}, out_busy, 0);
        check({tg, "_flush_novalid"}, out_fetch_valid, 0);
        tick();
        check({tg, "_flush_novalid2"}, out_fetch_valid, 0);
        return;
      end
      // Requests while busy must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        in_fetch_req = 1'b1;
        in_fetch_pc  = $urandom;
      end
      tick();
      in_fetch_req = 1'b0;
      check({tg, "_wait_memreq"}, out_mem_req, 1);
      check({tg, "_wait_addr"}, out_mem_addr, {pc[31:2], 2'b00});
      check({tg, "_wait_novalid"}, out_fetch_valid, 0);
    end
    in_mem_valid = 1'b1;
    in_mem_data  = mdata;
    in_misbranch = misb_fill;
    tick();
    in_mem_valid = 1'b0;
    in_misbranch = 1'b0;
    in_mem_data  = $urandom;
    mdl_fill(pc, mdata);
    if (!misb_fill) begin
      exp_q.push_back(mdata);
      check({tg, "_fill_valid"}, out_fetch_valid, 1);
      check_resp(tg);
    end else begin
      check({tg, "_fillflush_novalid"}, out_fetch_valid, 0);
    end
    check({tg, "_fill_busy"}, out_busy, 0);
    check({tg, "_fill_memreq"}, out_mem_req, 0);
    tick();
    check({tg, "_fill_pulse_end"}, out_fetch_valid, 0);
  endtask

  initial begin
    logic [31:0] pc;
    int lat, mat;
    mdl_clear();

    // Reset.
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_valid", out_fetch_valid, 0);
    check("rst_instr", out_fetch_instr, 0);
    check("rst_busy", out_busy, 0);
    check("rst_memreq", out_mem_req, 0);
    check("rst_addr", out_mem_addr, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();

    // Cold miss, hit, conflict.
    do_fetch(32'h0000_0100, 32'h0000_0513, 5, -1, 1'b0, "cold");
    do_fetch(32'h0000_0100, 32'hDEAD_0000, 5, -1, 1'b0, "hit");
    do_fetch(32'h0000_0200, 32'h1234_5678, 3, -1, 1'b0, "conflict");
    do_fetch(32'h0000_0100, 32'h0000_0513, 2, -1, 1'b0, "refill");

    // Flush mid-miss, then the same address misses again.
    do_fetch(32'h0000_0300, 32'hAAAA_0300, 5, 2, 1'b0, "flush_mid");
    do_fetch(32'h0000_0300, 32'hBBBB_0300, 1, -1, 1'b0, "after_flush");

    // Flush together with the memory word: filled but silent, then a hit.
    do_fetch(32'h0000_0400, 32'hCAFE_0400, 2, -1, 1'b1, "flush_fill");
    do_fetch(32'h0000_0400, 32'h0, 2, -1, 1'b0, "flush_fill_hit");

    // Flush in IDLE cancels a request that would hit, and one that would miss.
    in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0400; in_misbranch = 1'b1;
    tick();
    check("idle_flush_hit_novalid", out_fetch_valid, 0);
    in_fetch_pc = 32'h0000_0500;
    tick();
    in_fetch_req = 1'b0; in_misbranch = 1'b0;
    check("idle_flush_miss_busy", out_busy, 0);
    check("idle_flush_miss_novalid", out_fetch_valid, 0);

    // rdy low for 3 cycles while a hit response is out.
    in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0400;
    tick();
    in_fetch_req = 1'b0;
    rdy = 1'b0;
    check("rdy_resp_valid", out_fetch_valid, 1);
    check("rdy_resp_instr", out_fetch_instr, 32'hCAFE_0400);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rdy_hold_valid", out_fetch_valid, 1);
      check("rdy_hold_instr", out_fetch_instr, 32'hCAFE_0400);
    end
    rdy = 1'b1;
    tick();
    check("rdy_release_pulse_end", out_fetch_valid, 0);
    tick();
    check("rdy_release_no_repeat", out_fetch_valid, 0);

    // rdy low during a miss: a flush and memory word are both ignored.
    in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0600;
    tick();
    in_fetch_req = 1'b0;
    check("rdymiss_busy", out_busy, 1);
    rdy = 1'b0; in_misbranch = 1'b1; in_mem_valid = 1'b1; in_mem_data = 32'h5555_AAAA;
    tick();
    tick();
    check("rdymiss_hold_busy", out_busy, 1);
    check("rdymiss_hold_memreq", out_mem_req, 1);
    check("rdymiss_hold_addr", out_mem_addr, 32'h0000_0600);
    check("rdymiss_hold_novalid", out_fetch_valid, 0);
    rdy = 1'b1; in_misbranch = 1'b0; in_mem_data = 32'h0600_0600;
    tick();
    in_mem_valid = 1'b0;
    mdl_fill(32'h0000_0600, 32'h0600_0600);
    check("rdymiss_fill_valid", out_fetch_valid, 1);
    check("rdymiss_fill_instr", out_fetch_instr, 32'h0600_0600);
    tick();

    // Asynchronous reset in the middle of a miss.
    in_fetch_req = 1'b1; in_fetch_pc = 32'h0000_0700;
    tick();
    in_fetch_req = 1'b0;
    check("rstmiss_busy", out_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("rstmiss_valid", out_fetch_valid, 0);
    check("rstmiss_instr", out_fetch_instr, 0);
    check("rstmiss_busy0", out_busy, 0);
    check("rstmiss_memreq", out_mem_req, 0);
    check("rstmiss_addr", out_mem_addr, 0);
    mdl_clear();
    tick();
    rst = 1'b1;
    tick();
    do_fetch(32'h0000_0100, 32'h0000_0513, 1, -1, 1'b0, "post_rst");
    do_fetch(32'h0000_0700, 32'h0700_0700, 1, -1, 1'b0, "post_rst_700");

    // Random traffic over a few indices and tags so hits and conflicts mix;
    // random upper bits check that pc[31:18] is ignored by the lookup.
    for (int n = 0; n < 200; n++) begin
      pc = ($urandom_range(0, 3) << 18) | ($urandom_range(0, 2) << 8) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      lat = $urandom_range(0, 4);
      mat = -1;
      if (lat > 0 && $urandom_range(0, 7) == 0) mat = $urandom_range(0, lat - 1);
      do_fetch(pc, $urandom, lat, mat, ($urandom_range(0, 7) == 0), "rand");
    end

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 LINES, default 64, number of direct-mapped lines, one 32-bit word per line; power of two.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rdy  input  1  ready; when low, all state and outputs hold.
REQ-005 in_fetch_req  input  1  fetcher request; sampled only when out_busy=0.
REQ-006 in_fetch_pc  input  32  fetch address; bits [1:0] ignored.
REQ-007 in_misbranch  input  1  ROB flush; aborts any outstanding fetch.
REQ-008 out_fetch_valid  output  1  one-cycle pulse: out_fetch_instr is valid.
REQ-009 out_fetch_instr  output  32  returned instruction word.
REQ-010 out_busy  output  1  miss in progress; fetcher must not issue.
REQ-011 out_mem_req  output  1  level request to memCtrl for a 4-byte instruction read.
REQ-012 out_mem_addr  output  32  word-aligned miss address, stable while out_mem_req=1.
REQ-013 in_mem_valid  input  1  one-cycle pulse: memCtrl word available.
REQ-014 in_mem_data  input  32  assembled little-endian word from memCtrl.

Function
REQ-015 Address split: index = pc[2+log2(LINES)-1:2]; tag = pc[17:2+log2(LINES)]; bits above 17 ignored.
REQ-016 Storage per line: valid bit, tag, 32-bit data.
REQ-017 States: IDLE, MISS; reset state IDLE.
REQ-018 IDLE, req=1, hit (valid and tag match): next cycle out_fetch_valid=1 with stored data; state stays IDLE; latency 1 cycle.
REQ-019 IDLE, req=1, miss: next cycle state=MISS, out_busy=1, out_mem_req=1, out_mem_addr={pc[31:2],2'b00}; pc latched internally.
REQ-020 MISS, in_mem_valid=1: write line (valid=1, tag, data); next cycle out_fetch_valid=1, out_fetch_instr=in_mem_data, out_mem_req=0, out_busy=0, state=IDLE.
REQ-021 out_fetch_valid is high for exactly one cycle per completed request; otherwise 0.
REQ-022 in_misbranch=1 in IDLE: any pending hit response is suppressed (no out_fetch_valid next cycle); request on same cycle ignored.
REQ-023 in_misbranch=1 in MISS without in_mem_valid: next cycle state=IDLE, out_mem_req=0, out_busy=0, no fill, no response.
REQ-024 in_misbranch and in_mem_valid in the same cycle: line is filled (data is correct for its address), response suppressed, state=IDLE.
REQ-025 in_fetch_req while out_busy=1 is ignored.
REQ-026 rdy=0: no state, array, or output changes; in_mem_valid pulses during rdy=0 are not required to be captured (memCtrl also freezes).
REQ-027 Misbranch never invalidates lines; no self-modifying-code coherence.

Reset
REQ-028 On rst=0 (asynchronous): state=IDLE, all valid bits=0, out_fetch_valid=0, out_fetch_instr=0, out_busy=0, out_mem_req=0, out_mem_addr=0.
REQ-029 Reset asserted mid-miss aborts the miss with no fill; first request after release misses.
REQ-030 Tag/data arrays need not be reset.

Structure
REQ-031 DATA_WIDTH, RAM_ADDRESS_WIDTH and ICACHE index/tag widths are defined in the shared constants header.
REQ-032 Single module, no sub-modules; arrays inferred as registers.

Verification
REQ-033 Cold miss: req pc=0x0000_0100, mem returns 0x0000_0513 after 5 cycles -> out_mem_addr=0x100 held 5 cycles, then valid pulse with 0x0000_0513.
REQ-034 Hit: repeat pc=0x100 -> out_fetch_valid next cycle, 0x0000_0513, out_mem_req stays 0.
REQ-035 Conflict: pc=0x200 (same index, LINES=64) fills 0x1234_5678; then pc=0x100 -> miss again.
REQ-036 Misbranch mid-miss: pc=0x300 miss, misbranch 2 cycles later -> out_mem_req drops, no valid pulse; later pc=0x300 -> miss.
REQ-037 Misbranch coincident with in_mem_valid for pc=0x400 -> no valid pulse; next pc=0x400 request hits.
REQ-038 rdy low 3 cycles during hit response -> out_fetch_valid held, pulse emitted exactly once after rdy returns; rst=0 mid-miss -> all outputs 0 immediately.
